// File: rtl/aes_block_packer.sv
// Packs an 8-bit valid/ready byte stream into 128-bit AES blocks with a per-block key snapshot.
// Optional macro AES_PKCS7_PAD_EN selects PKCS#7 padding; the default build zero-fills short blocks.
module aes_block_packer #(
    parameter int BYTE_W = 8,
    parameter int BLK_W  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  key_in,
    input  logic              key_load,
    output logic [BLK_W-1:0]  block_out,
    output logic [BLK_W-1:0]  key_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [4:0]        out_nbytes
);
    localparam int NBYTES = BLK_W / BYTE_W;

`ifdef AES_PKCS7_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {FILL, HOLD, PAD} state_t;

    state_t           state, next_state;
    logic [3:0]       cnt;
    logic [BLK_W-1:0] block_q, block_d;
    logic [BLK_W-1:0] key_reg;
    logic             pad_pending;
    logic [7:0]       fill_byte;
    logic             xfer, blk_done, full_last;

    assign xfer      = in_valid & in_ready;
    assign blk_done  = xfer & ((cnt == 4'hf) | in_last);
    // A message ending exactly on a block boundary still owes a whole padding block.
    assign full_last = PAD_EN & in_last & (cnt == 4'hf);
    assign fill_byte = PAD_EN ? {4'h0, 4'hf - cnt} : 8'h00;
    assign block_out = block_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= next_state;
    end

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (blk_done)  next_state = HOLD;
            HOLD:    if (out_ready) next_state = pad_pending ? PAD : FILL;
            PAD:     if (out_ready) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state != FILL);
    end

    // Merge the incoming byte and, on the final byte, fill the unused tail.
    always_comb begin
        block_d = block_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (4'(i) == cnt)
                block_d[BLK_W-1-BYTE_W*i -: BYTE_W] = in_byte;
            else if ((4'(i) > cnt) && in_last)
                block_d[BLK_W-1-BYTE_W*i -: BYTE_W] = fill_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'h0;
            block_q     <= '0;
            key_reg     <= '0;
            key_out     <= '0;
            out_last    <= 1'b0;
            out_nbytes  <= 5'd0;
            pad_pending <= 1'b0;
        end else begin
            if (key_load) key_reg <= key_in;
            case (state)
                FILL: if (xfer) begin
                    block_q <= block_d;
                    cnt     <= blk_done ? 4'h0 : cnt + 4'h1;
                    if (blk_done) begin
                        key_out     <= key_load ? key_in : key_reg;
                        out_last    <= in_last & ~full_last;
                        out_nbytes  <= {1'b0, cnt} + 5'd1;
                        pad_pending <= full_last;
                    end
                end
                HOLD: if (out_ready) begin
                    if (pad_pending) begin
                        block_q     <= {NBYTES{8'h10}};
                        out_last    <= 1'b1;
                        out_nbytes  <= 5'd0;
                        pad_pending <= 1'b0;
                    end else begin
                        out_last   <= 1'b0;
                        out_nbytes <= 5'd0;
                    end
                end
                PAD: if (out_ready) begin
                    out_last   <= 1'b0;
                    out_nbytes <= 5'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed scenarios plus random traffic against a queue model.
module tb_aes_block_packer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_byte;
    logic         in_valid, in_last, in_ready;
    logic [127:0] key_in, block_out, key_out;
    logic         key_load, out_valid, out_ready, out_last;
    logic [4:0]   out_nbytes;

`ifdef AES_PKCS7_PAD_EN
    localparam bit PAD_EN = 1'b1;
    localparam logic [127:0] SHORT_EXP = 128'haaabacadae0b0b0b0b0b0b0b0b0b0b0b;
`else
    localparam bit PAD_EN = 1'b0;
    localparam logic [127:0] SHORT_EXP = 128'haaabacadae0000000000000000000000;
`endif
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] blk;
        logic [127:0] key;
        logic         last;
        logic [4:0]   nb;
    } exp_t;

    exp_t         pend[$];
    logic [7:0]   part[$];
    logic [7:0]   msg[$];
    logic [127:0] m_key;
    int           errors = 0;
    int           checks = 0;

    aes_block_packer dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .key_in(key_in), .key_load(key_load),
        .block_out(block_out), .key_out(key_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_nbytes(out_nbytes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: collect bytes of the current block; a block closes at 16 bytes or on in_last.
    task automatic model_accept(input logic [7:0] b, input logic l);
        exp_t         e;
        logic [127:0] blk;
        int           n;
        part.push_back(b);
        if (part.size() == 16 || l) begin
            n = part.size();
            for (int i = 0; i < 16; i++)
                blk[127-8*i -: 8] = (i < n) ? part[i] : (PAD_EN ? 8'(16 - n) : 8'h00);
            e.blk = blk;
            e.key = m_key;
            if (PAD_EN && l && n == 16) begin
                e.last = 1'b0; e.nb = 5'd16;
                pend.push_back(e);
                e.blk = {16{8'h10}}; e.last = 1'b1; e.nb = 5'd0;
                pend.push_back(e);
            end else begin
                e.last = l; e.nb = 5'(n);
                pend.push_back(e);
            end
            part.delete();
        end
    endtask

    task automatic check_outs();
        check("in_ready", 128'(in_ready), 128'(pend.size() == 0));
        check("out_valid", 128'(out_valid), 128'(pend.size() != 0));
        if (pend.size() != 0) begin
            check("block_out", block_out, pend[0].blk);
            check("key_out", key_out, pend[0].key);
            check("out_last", 128'(out_last), 128'(pend[0].last));
            check("out_nbytes", 128'(out_nbytes), 128'(pend[0].nb));
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] b, input logic l,
                        input logic kl, input logic [127:0] k, input logic ordy);
        in_valid = v; in_byte = b; in_last = l; key_load = kl; key_in = k; out_ready = ordy;
        @(posedge clk);
        if (kl) m_key = k;
        if (pend.size() != 0) begin
            if (ordy) void'(pend.pop_front());
        end else if (v) begin
            model_accept(b, l);
        end
        #1;
        check_outs();
    endtask

    task automatic send_msg(input bit with_last, input int ordy_pct, input int gap_pct, input int kl_pct);
        int   idx = 0;
        int   budget = 0;
        logic v, ordy, kl, acc, l;
        while (idx < msg.size() && budget < 2000) begin
            v    = ($urandom_range(99) >= gap_pct);
            ordy = ($urandom_range(99) < ordy_pct);
            kl   = ($urandom_range(99) < kl_pct);
            acc  = v && (pend.size() == 0);
            l    = with_last && (idx == msg.size() - 1);
            tick(v, msg[idx], l, kl, {$urandom, $urandom, $urandom, $urandom}, ordy);
            if (acc) idx++;
            budget++;
        end
        check("send_done", 128'(idx), 128'(msg.size()));
    endtask

    task automatic drain();
        int b = 0;
        while (pend.size() != 0 && b < 100) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
            b++;
        end
        check("drained", 128'(out_valid), 128'(0));
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; key_load = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        pend.delete(); part.delete(); m_key = '0;
        check_outs();
        check("rst_block", block_out, 128'(0));
        check("rst_key", key_out, 128'(0));
        check("rst_last", 128'(out_last), 128'(0));
        check("rst_nbytes", 128'(out_nbytes), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_random(input int n);
        msg.delete();
        repeat (n) msg.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] b17;
        rst_n = 1'b1; in_byte = '0; in_valid = 0; in_last = 0; key_in = '0; key_load = 0; out_ready = 0;
        m_key = '0;
        #2;
        do_reset();

        // Known-answer block: bytes 00..0f under key 00..0f, full rate.
        tick(1'b0, 8'h00, 1'b0, 1'b1, KEY0, 1'b1);
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(i));
        send_msg(1'b0, 100, 0, 0);
        check("kat_block", block_out, 128'h000102030405060708090a0b0c0d0e0f);
        check("kat_nbytes", 128'(out_nbytes), 128'(16));
        drain();

        // Backpressure: block held for 10 cycles while the 17th byte waits.
        fill_random(16);
        send_msg(1'b0, 0, 0, 0);
        b17 = 8'($urandom);
        repeat (10) tick(1'b1, b17, 1'b0, 1'b0, '0, 1'b0);
        fill_random(15);
        msg.push_front(b17);
        send_msg(1'b0, 100, 0, 0);
        drain();

        // Short final block, then a key change while the block is held.
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'hAA + 8'(i));
        send_msg(1'b1, 0, 0, 0);
        check("short_blk", block_out, SHORT_EXP);
        check("short_last", 128'(out_last), 128'(1));
        check("short_nbytes", 128'(out_nbytes), 128'(5));
        tick(1'b0, 8'h00, 1'b0, 1'b1, KEY1, 1'b0);
        check("key_hold", key_out, KEY0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
        fill_random(16);
        send_msg(1'b0, 100, 0, 0);
        check("key_new", key_out, KEY1);
        drain();

        // Message ending exactly on a block boundary.
        fill_random(16);
        send_msg(1'b1, 0, 0, 0);
        check("full_last", 128'(out_last), 128'(!PAD_EN));
        drain();

        // Random messages with gaps, backpressure and key reloads.
        repeat (40) begin
            fill_random($urandom_range(1, 40));
            send_msg(1'b1, 60, 30, 10);
        end
        drain();

        // Reset in the middle of a block discards the partial data.
        fill_random(7);
        send_msg(1'b0, 100, 0, 0);
        do_reset();
        fill_random(16);
        send_msg(1'b0, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
